alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, registered successor to the processor's single-cycle 16-bit ALU.
- Same 4-bit function encoding. Adds:
  - a generic data width;
  - a valid/ready handshake on input and output;
  - a persistent NZCV flag register;
  - an iterative barrel-free shifter (one bit per cycle);
  - correct signed branch conditions.
- Sits between register-file read and writeback / PC-update logic.

Parameters:
- WIDTH, 16, datapath width in bits; must be a power of two and at least 4.
- SHAMT_W, $clog2(WIDTH)+1, width of the shift counter (holds 0..WIDTH).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept an operation this cycle.
- func  in  4  function: 0 JMP, 1 ADD, 2 SUB, 3 LSL, 4 LSR, 5 AND, 6 OR, 7 XOR, 8 LD, 9 ST, A MOV, B BEQ, C BNE, D BLT, E BGT, F CMP.
- op0  in  WIDTH  operand 0 / branch target A.
- op1  in  WIDTH  operand 1 / shift amount / branch target B.
- flag_en  in  1  commit this operation's flags.
- b_sel  in  1  branch/jump target select: 1 = op1, 0 = op0.
- out_valid  out  1  result held on q / b_out.
- out_ready  in  1  consumer takes the result.
- q  out  WIDTH  result.
- flags  out  4  registered flags: [3] C, [2] N, [1] V, [0] Z.
- b_out  out  1  branch taken.

Behaviour:
- Reset (asynchronous): state IDLE, q=0, flags=0, b_out=0, out_valid=0, shift counter=0. Reset mid-shift aborts the operation; nothing is emitted.
- States:
  - IDLE: accept when in_valid && in_ready; latch func, op0, op1, flag_en, b_sel.
    - Non-shift op: result registered in the same edge; out_valid=1 next cycle (latency 1).
    - Shift op: load cnt = min(op1, WIDTH) and go to SHIFT.
  - SHIFT: each cycle, shift the working register by 1 and decrement cnt. C tracks the last bit shifted out. At cnt==0, register the result, set out_valid and return to IDLE. Latency = 1 + min(op1, WIDTH). A zero amount gives result op0 with C=0.
- in_ready = (state==IDLE) && (!out_valid || out_ready). A same-cycle output handshake and new acceptance is allowed, giving back-to-back throughput of 1 per cycle for non-shift ops.
- out_valid, q and b_out hold stable until out_ready is sampled high. out_valid then drops unless a new result is registered in the same edge.
- Arithmetic is modulo 2^WIDTH.
  - ADD: C = carry out of bit WIDTH-1; V = (op0 and op1 MSBs equal) && (result MSB differs from op0 MSB).
  - SUB/CMP: op0 + ~op1 + 1. C = carry out (1 = no borrow). V = (op0 and op1 MSBs differ) && (result MSB differs from op0 MSB).
  - N = result MSB; Z = (result==0). N and Z are computed from the new result, never the previous q.
- Logic ops (AND/OR/XOR): C=0, V=0. Shifts: V=0.
- LD, ST, MOV: q = op0+op1. With flag_en, flags are cleared to 0.
- JMP: q = selected target, b_out=1.
- Branches evaluate the registered flags at acceptance time:
  - BEQ: Z
  - BNE: !Z
  - BLT: N!=V
  - BGT: !Z && N==V
  - Taken: q = selected target, b_out=1. Not taken: q=0, b_out=0.
- Flags are written at the same edge the result is registered. Only flag_en ops and CMP write them; CMP writes regardless of flag_en. Branch and JMP ops never modify flags.
- b_out=0 for all non-branch, non-JMP ops.

Optional Feature:
- Macro ALU_SEQ_CARRY_CHAIN_EN.
- Defined: ADD with flag_en adds the registered C as carry-in (ADC). SUB with flag_en uses op0 + ~op1 + C (SBC).
- Undefined: carry-in is fixed at 0 for ADD and at 1 for SUB.
- CMP is unaffected in both cases.

Decomposition:
- Shared package alu_pkg holds:
  - function-code localparams (ALU_JMP … ALU_CMP);
  - flag bit indices (FLAG_C=3, FLAG_N=2, FLAG_V=1, FLAG_Z=0);
  - the state encoding (IDLE, SHIFT).
- One sub-module, alu_branch_cond: a combinational map of func and flags to taken. It is reused later by the fetch unit.

Test Plan:
- ADD, WIDTH=16, op0=7FFF, op1=0001, flag_en=1 -> q=8000, flags N=1 V=1 C=0 Z=0; out_valid one cycle after acceptance.
- CMP 0005 vs 0005, then BEQ with b_sel=1, op1=0040 -> Z=1, second result q=0040, b_out=1; flags unchanged by BEQ.
- LSL op0=8001, op1=3 -> in_ready low for 3 cycles, q=0008, C=0. Then LSR op0=0001, op1=20 (clamped to 16) -> q=0, C=0, Z=1, latency 17.
- Hold out_ready=0 for 4 cycles after an ADD -> q and out_valid stable, in_ready=0. Release with a new in_valid in the same cycle -> back-to-back acceptance.
- Assert rst during SHIFT (cnt=5) -> out_valid=0, flags=0, q=0 immediately; no result is emitted after release.
- With ALU_SEQ_CARRY_CHAIN_EN: ADD FFFF+0001 (C=1 result), then ADD 0000+0000 with flag_en -> q=0001.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: function codes, flag bit positions and FSM states.
package alu_pkg;

  localparam logic [3:0] ALU_JMP = 4'h0;
  localparam logic [3:0] ALU_ADD = 4'h1;
  localparam logic [3:0] ALU_SUB = 4'h2;
  localparam logic [3:0] ALU_LSL = 4'h3;
  localparam logic [3:0] ALU_LSR = 4'h4;
  localparam logic [3:0] ALU_AND = 4'h5;
  localparam logic [3:0] ALU_OR  = 4'h6;
  localparam logic [3:0] ALU_XOR = 4'h7;
  localparam logic [3:0] ALU_LD  = 4'h8;
  localparam logic [3:0] ALU_ST  = 4'h9;
  localparam logic [3:0] ALU_MOV = 4'hA;
  localparam logic [3:0] ALU_BEQ = 4'hB;
  localparam logic [3:0] ALU_BNE = 4'hC;
  localparam logic [3:0] ALU_BLT = 4'hD;
  localparam logic [3:0] ALU_BGT = 4'hE;
  localparam logic [3:0] ALU_CMP = 4'hF;

  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic logic is_shift(input logic [3:0] f);
    return (f == ALU_LSL) || (f == ALU_LSR);
  endfunction

endpackage

// File: rtl/alu_branch_cond.sv
// Maps a function code and the NZCV flags to "branch taken"; JMP is always taken.
module alu_branch_cond
  import alu_pkg::*;
(
  input  logic [3:0] func,
  input  logic [3:0] flags,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (func)
      ALU_JMP: taken = 1'b1;
      ALU_BEQ: taken = flags[FLAG_Z];
      ALU_BNE: taken = !flags[FLAG_Z];
      ALU_BLT: taken = flags[FLAG_N] != flags[FLAG_V];
      ALU_BGT: taken = !flags[FLAG_Z] && (flags[FLAG_N] == flags[FLAG_V]);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake, NZCV flag register and a one-bit-per-cycle shifter.
// Define ALU_SEQ_CARRY_CHAIN_EN to feed the registered C into flag-setting ADD/SUB (ADC/SBC).
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       func,
  input  logic [WIDTH-1:0] op0,
  input  logic [WIDTH-1:0] op1,
  input  logic             flag_en,
  input  logic             b_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [3:0]       flags,
  output logic             b_out
);

  localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

  state_t             state;
  logic [SHAMT_W-1:0] cnt;
  logic [WIDTH-1:0]   wk;
  logic [3:0]         func_r;
  logic               flag_en_r;

  logic               accept, taken;
  logic               shift_p0, cin_p0, c_p0, v_p0, b_p0, fwr_p0, fclr_p0;
  logic [WIDTH:0]     sum_p0;
  logic [WIDTH-1:0]   addend_p0, res_p0;
  logic [SHAMT_W-1:0] amt_p0;
  logic [WIDTH-1:0]   wk_nxt;
  logic               c_sh;

  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

  function automatic logic [3:0] pack_flags(input logic c, input logic n, input logic v,
                                            input logic z);
    logic [3:0] f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_N] = n;
    f[FLAG_V] = v;
    f[FLAG_Z] = z;
    return f;
  endfunction

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Branches see the flags as registered when the branch is accepted.
  alu_branch_cond u_cond (
    .func  (func),
    .flags (flags),
    .taken (taken)
  );

  // Stage p0: combinational evaluation of the presented operation
  always_comb begin
    shift_p0  = is_shift(func);
    addend_p0 = ((func == ALU_SUB) || (func == ALU_CMP)) ? ~op1 : op1;
    cin_p0    = (func == ALU_SUB) || (func == ALU_CMP);
`ifdef ALU_SEQ_CARRY_CHAIN_EN
    if (flag_en && ((func == ALU_ADD) || (func == ALU_SUB))) cin_p0 = flags[FLAG_C];
`endif
    sum_p0 = {1'b0, op0} + {1'b0, addend_p0} + {{WIDTH{1'b0}}, cin_p0};
    // Any op1 >= WIDTH saturates the shift count at WIDTH.
    amt_p0 = (|(op1 >> (SHAMT_W - 1))) ? {1'b1, {(SHAMT_W-1){1'b0}}}
                                       : {1'b0, op1[SHAMT_W-2:0]};
    res_p0  = sum_p0[WIDTH-1:0];
    c_p0    = 1'b0;
    v_p0    = 1'b0;
    b_p0    = 1'b0;
    fwr_p0  = flag_en;
    fclr_p0 = 1'b0;
    case (func)
      ALU_ADD: begin
        c_p0 = sum_p0[WIDTH];
        v_p0 = add_ovf(op0[WIDTH-1], op1[WIDTH-1], res_p0[WIDTH-1]);
      end
      ALU_SUB, ALU_CMP: begin
        c_p0   = sum_p0[WIDTH];
        v_p0   = sub_ovf(op0[WIDTH-1], op1[WIDTH-1], res_p0[WIDTH-1]);
        fwr_p0 = flag_en || (func == ALU_CMP);
      end
      ALU_AND: res_p0 = op0 & op1;
      ALU_OR:  res_p0 = op0 | op1;
      ALU_XOR: res_p0 = op0 ^ op1;
      ALU_LSL, ALU_LSR: res_p0 = op0;
      ALU_LD, ALU_ST, ALU_MOV: fclr_p0 = 1'b1;
      ALU_JMP, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGT: begin
        res_p0 = taken ? (b_sel ? op1 : op0) : '0;
        b_p0   = taken;
        fwr_p0 = 1'b0;
      end
      default: res_p0 = sum_p0[WIDTH-1:0];
    endcase
  end

  always_comb begin
    if (func_r == ALU_LSL) {c_sh, wk_nxt} = {wk, 1'b0};
    else                   {wk_nxt, c_sh} = {1'b0, wk};
  end

  // Stage p1: FSM, held result and flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      q         <= '0;
      flags     <= '0;
      b_out     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (shift_p0 && (amt_p0 != '0)) begin
              state <= SHIFT;
              cnt   <= amt_p0;
            end else begin
              q         <= res_p0;
              b_out     <= b_p0;
              out_valid <= 1'b1;
              if (fwr_p0)
                flags <= fclr_p0 ? '0
                                 : pack_flags(c_p0, res_p0[WIDTH-1], v_p0, res_p0 == '0);
            end
          end
        end
        SHIFT: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state     <= IDLE;
            q         <= wk_nxt;
            b_out     <= 1'b0;
            out_valid <= 1'b1;
            if (flag_en_r) flags <= pack_flags(c_sh, wk_nxt[WIDTH-1], 1'b0, wk_nxt == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      wk        <= op0;
      func_r    <= func;
      flag_en_r <= flag_en;
    end else if (state == SHIFT) begin
      wk <= wk_nxt;
    end
  end

endmodule
